// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the load/store sequencer: funct3 codes, FSM states
// and the acceptance-time fault rule.
package mem_access_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_CAPT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Misalignment or an encoding with no legal meaning for the direction.
  function automatic logic access_fault(input logic       we,
                                        input logic [2:0] func3,
                                        input logic [1:0] addr_lo);
    return ((func3[1:0] == 2'b01) && addr_lo[0])
         || ((func3[1:0] == 2'b10) && (addr_lo != 2'b00))
         || (we && (func3 > 3'd2))
         || (!we && ((func3 == 3'd3) || (func3 == 3'd6) || (func3 == 3'd7)));
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Core request/response and RAM-side signals of mem_access_ctrl.
// The slave modport is the controller; the master drives requests and RAM data.
interface mem_access_ctrl_if #(parameter int ADDR_W = 8);
  logic              iREQ;
  logic              iWE;
  logic [2:0]        iFUNC3;
  logic [31:0]       iADDR;
  logic [31:0]       iWDATA;
  logic              oREADY;
  logic              oDONE;
  logic              oFAULT;
  logic [31:0]       oRDATA;
  logic              oRAM_CE;
  logic              oRAM_RD;
  logic              oRAM_WR;
  logic [ADDR_W-1:0] oRAM_ADDR;
  logic [31:0]       iRAM_DATA;
  logic [31:0]       oRAM_DATA;

  modport slave (
    input  iREQ, iWE, iFUNC3, iADDR, iWDATA, iRAM_DATA,
    output oREADY, oDONE, oFAULT, oRDATA,
           oRAM_CE, oRAM_RD, oRAM_WR, oRAM_ADDR, oRAM_DATA
  );

  modport master (
    output iREQ, iWE, iFUNC3, iADDR, iWDATA, iRAM_DATA,
    input  oREADY, oDONE, oFAULT, oRDATA,
           oRAM_CE, oRAM_RD, oRAM_WR, oRAM_ADDR, oRAM_DATA
  );
endinterface

// File: rtl/mem_access_ctrl_lane_align.sv
// Combinational byte-lane steering: store merge into the held RAM word and
// load lane extraction with sign/zero extension.
module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_hold,
  input  logic [31:0] i_rword,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_func3,
  output logic [31:0] o_wword,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rword[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_rword[{i_addr_lo[1], 4'b0000} +: 16];

  // Store merge: only the addressed lane(s) take new data.
  always_comb begin
    o_wword = i_hold;
    case (i_func3[1:0])
      2'b00:   o_wword[{i_addr_lo, 3'b000} +: 8]     = i_wdata[7:0];
      2'b01:   o_wword[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
      2'b10:   o_wword = i_wdata;
      default: o_wword = i_hold;
    endcase
  end

  // Load extract and extend.
  always_comb begin
    o_rdata = 32'h0000_0000;
    case (i_func3)
      F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
      F3_W:    o_rdata = i_rword;
      F3_BU:   o_rdata = {24'h00_0000, w_byte};
      F3_HU:   o_rdata = {16'h0000, w_half};
      default: o_rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle load/store sequencer to a single-port 32-bit RAM: single read,
// single write (SW) or read-modify-write (SB/SH), with fault detection.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic               iCLK,
  input  logic               iRST,
  mem_access_ctrl_if.slave   bus
);

  state_t            r_state;
  state_t            w_next;
  logic              r_we;
  logic [2:0]        r_func3;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_hold;
  logic [31:0]       r_rdata;
  logic              r_fault;

  logic              w_fault;
  logic              w_accept;
  logic [31:0]       w_wword;
  logic [31:0]       w_rdata;

  assign w_fault  = access_fault(bus.iWE, bus.iFUNC3, bus.iADDR[1:0]);
  assign w_accept = bus.iREQ && (r_state == ST_IDLE);

  mem_lane_align u_align (
    .i_wdata   (r_wdata),
    .i_hold    (r_hold),
    .i_rword   (bus.iRAM_DATA),
    .i_addr_lo (r_addr[1:0]),
    .i_func3   (r_func3),
    .o_wword   (w_wword),
    .o_rdata   (w_rdata)
  );

  // State register.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.iREQ) begin
          if (w_fault) begin
            w_next = ST_DONE;
          end else if (bus.iWE && (bus.iFUNC3 == F3_W)) begin
            w_next = ST_WRITE;
          end else begin
            w_next = ST_READ;
          end
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_READ:  w_next = ST_CAPT;
      ST_CAPT: begin
        if (r_we) begin
          w_next = ST_WRITE;
        end else begin
          w_next = ST_DONE;
        end
      end
      ST_WRITE: w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Request latches, RMW hold word and load result.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_we    <= 1'b0;
      r_func3 <= 3'd0;
      r_addr  <= '0;
      r_wdata <= 32'h0000_0000;
      r_hold  <= 32'h0000_0000;
      r_rdata <= 32'h0000_0000;
      r_fault <= 1'b0;
    end else if (w_accept) begin
      r_we    <= bus.iWE;
      r_func3 <= bus.iFUNC3;
      r_addr  <= bus.iADDR[ADDR_W+1:0];
      r_wdata <= bus.iWDATA;
      r_fault <= w_fault;
    end else if (r_state == ST_CAPT) begin
      r_hold <= bus.iRAM_DATA;
      // Loads leave CAPT straight into DONE, so the result lands on DONE entry.
      if (!r_we) begin
        r_rdata <= w_rdata;
      end
    end
  end

  // Status and RAM strobe decode from the current state.
  always_comb begin
    bus.oREADY    = (r_state == ST_IDLE);
    bus.oDONE     = (r_state == ST_DONE);
    bus.oFAULT    = (r_state == ST_DONE) && r_fault;
    bus.oRDATA    = r_rdata;
    bus.oRAM_CE   = 1'b0;
    bus.oRAM_RD   = 1'b0;
    bus.oRAM_WR   = 1'b0;
    bus.oRAM_ADDR = '0;
    bus.oRAM_DATA = 32'h0000_0000;
    case (r_state)
      ST_READ: begin
        bus.oRAM_CE   = 1'b1;
        bus.oRAM_RD   = 1'b1;
        bus.oRAM_ADDR = r_addr[ADDR_W+1:2];
      end
      ST_WRITE: begin
        bus.oRAM_CE   = 1'b1;
        bus.oRAM_WR   = 1'b1;
        bus.oRAM_ADDR = r_addr[ADDR_W+1:2];
        bus.oRAM_DATA = w_wword;
      end
      default: begin
        bus.oRAM_CE = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a behavioural registered-read RAM.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  localparam int ADDR_W = 8;

  logic iCLK = 1'b0;
  logic iRST = 1'b1;
  always #5 iCLK = ~iCLK;

  mem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus();

  mem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus)
  );

  typedef struct {
    string       name;
    logic        fault;
    logic        chk;
    logic [31:0] rdata;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  // RAM model and edge counter
  logic [31:0]       mem [0:255];
  logic [31:0]       ram_q = 32'h0;
  int                cyc = 0;
  logic              pre_en = 1'b0;
  logic [7:0]        pre_addr = 8'h0;
  logic [31:0]       pre_data = 32'h0;
  int                ce_count = 0;
  int                wr_cyc = -1;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [31:0]       wr_data = 32'h0;

  assign bus.iRAM_DATA = ram_q;

  always @(posedge iCLK) begin
    cyc <= cyc + 1;
    if (bus.oRAM_CE && bus.oRAM_RD) ram_q <= mem[bus.oRAM_ADDR];
    if (bus.oRAM_CE && bus.oRAM_WR) mem[bus.oRAM_ADDR] <= bus.oRAM_DATA;
    else if (pre_en) mem[pre_addr] <= pre_data;
  end

  always @(negedge iCLK) begin
    if (bus.oRAM_CE) ce_count = ce_count + 1;
    if (bus.oRAM_CE && bus.oRAM_WR) begin
      wr_cyc  = cyc;
      wr_addr = bus.oRAM_ADDR;
      wr_data = bus.oRAM_DATA;
    end
  end

  // Monitor: pops an expectation for every completion pulse
  always @(negedge iCLK) begin
    if (!iRST && bus.oDONE) begin
      if (sbq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done: oDONE seen at cycle %0d with nothing outstanding", cyc);
      end else begin
        mon_e = sbq.pop_front();
        checks++;
        if (bus.oFAULT !== mon_e.fault) begin
          failures++;
          $display("FAIL %s_fault: got %b expected %b", mon_e.name, bus.oFAULT, mon_e.fault);
        end
        checks++;
        if ((cyc - mon_e.acc + 1) != mon_e.lat) begin
          failures++;
          $display("FAIL %s_latency: got %0d expected %0d", mon_e.name, cyc - mon_e.acc + 1, mon_e.lat);
        end
        if (mon_e.chk) begin
          checks++;
          if (bus.oRDATA !== mon_e.rdata) begin
            failures++;
            $display("FAIL %s_rdata: got %h expected %h", mon_e.name, bus.oRDATA, mon_e.rdata);
          end
        end
      end
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge iCLK);
    pre_addr = a; pre_data = d; pre_en = 1'b1;
    @(negedge iCLK);
    pre_en = 1'b0;
  endtask

  task automatic issue(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic efault, input logic echk, input logic [31:0] erdata,
                       input int elat, input int force_acc, output int acc);
    exp_t e;
    int   n;
    @(negedge iCLK);
    bus.iREQ = 1'b1; bus.iWE = we; bus.iFUNC3 = f3; bus.iADDR = addr; bus.iWDATA = wdata;
    n = 0;
    while (!bus.oREADY && n < 40) begin
      @(negedge iCLK);
      n++;
    end
    if (!bus.oREADY) begin
      checks++; failures++;
      $display("FAIL %s_accept_timeout: oREADY still %b after %0d cycles", name, bus.oREADY, n);
      bus.iREQ = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    if (force_acc >= 0) begin
      checks++;
      if (acc != force_acc) begin
        failures++;
        $display("FAIL %s_accept_cycle: got %0d expected %0d", name, acc, force_acc);
      end
    end
    e.name = name; e.fault = efault; e.chk = echk; e.rdata = erdata; e.lat = elat;
    e.acc  = (force_acc >= 0) ? force_acc : acc;
    sbq.push_back(e);
    @(posedge iCLK);
    #1 bus.iREQ = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 60) begin
      @(negedge iCLK);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++; failures++;
      $display("FAIL %s_done_timeout: %0d completions missing", name, sbq.size());
      sbq.delete();
    end
    @(negedge iCLK);
  endtask

  task automatic check_reset_vals(input string tag);
    check32({tag, "_ready"}, {31'd0, bus.oREADY}, 32'd1);
    check32({tag, "_done"},  {31'd0, bus.oDONE},  32'd0);
    check32({tag, "_fault"}, {31'd0, bus.oFAULT}, 32'd0);
    check32({tag, "_rdata"}, bus.oRDATA, 32'h0);
    check32({tag, "_strobes"}, {29'd0, bus.oRAM_CE, bus.oRAM_RD, bus.oRAM_WR}, 32'd0);
    check32({tag, "_ram_addr"}, {24'd0, bus.oRAM_ADDR}, 32'd0);
    check32({tag, "_ram_data"}, bus.oRAM_DATA, 32'h0);
  endtask

  initial begin
    int a0, a1, ce0;
    bus.iREQ = 1'b0; bus.iWE = 1'b0; bus.iFUNC3 = 3'd0; bus.iADDR = 32'h0; bus.iWDATA = 32'h0;
    iRST = 1'b1;
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    check_reset_vals("reset");
    iRST = 1'b0;

    // SW: one write in cycle 1, done in cycle 2
    issue("sw", 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0, 2, -1, a0);
    wait_idle("sw");
    check32("sw_mem", mem[4], 32'hDEADBEEF);
    check32("sw_wr_cycle", wr_cyc - a0 + 1, 32'd1);
    check32("sw_wr_addr", {24'd0, wr_addr}, 32'd4);
    check32("sw_wr_data", wr_data, 32'hDEADBEEF);

    // Loads from 0x8000F0FF
    preload(8'd4, 32'h8000F0FF);
    issue("lb",  1'b0, F3_B,  32'h10, 32'h0, 1'b0, 1'b1, 32'hFFFFFFFF, 3, -1, a0);
    wait_idle("lb");
    issue("lbu", 1'b0, F3_BU, 32'h10, 32'h0, 1'b0, 1'b1, 32'h000000FF, 3, -1, a0);
    wait_idle("lbu");
    issue("lh",  1'b0, F3_H,  32'h12, 32'h0, 1'b0, 1'b1, 32'hFFFF8000, 3, -1, a0);
    wait_idle("lh");
    issue("lhu", 1'b0, F3_HU, 32'h12, 32'h0, 1'b0, 1'b1, 32'h00008000, 3, -1, a0);
    wait_idle("lhu");
    issue("lbu_b1", 1'b0, F3_BU, 32'h11, 32'h0, 1'b0, 1'b1, 32'h000000F0, 3, -1, a0);
    wait_idle("lbu_b1");
    issue("lw",  1'b0, F3_W,  32'h10, 32'h0, 1'b0, 1'b1, 32'h8000F0FF, 3, -1, a0);
    wait_idle("lw");

    // Faults: no RAM access, oRDATA kept
    ce0 = ce_count;
    issue("flt_lw",  1'b0, F3_W,  32'h13, 32'h0, 1'b1, 1'b1, 32'h8000F0FF, 1, -1, a0);
    wait_idle("flt_lw");
    issue("flt_sh",  1'b1, F3_H,  32'h11, 32'h0, 1'b1, 1'b1, 32'h8000F0FF, 1, -1, a0);
    wait_idle("flt_sh");
    issue("flt_st3", 1'b1, 3'd3,  32'h10, 32'h0, 1'b1, 1'b1, 32'h8000F0FF, 1, -1, a0);
    wait_idle("flt_st3");
    check32("flt_no_ce", ce_count - ce0, 32'd0);

    // SB / SH read-modify-write
    preload(8'd4, 32'h11223344);
    issue("sb", 1'b1, F3_B, 32'h12, 32'h000000AA, 1'b0, 1'b1, 32'h8000F0FF, 4, -1, a0);
    wait_idle("sb");
    check32("sb_mem", mem[4], 32'h11AA3344);
    preload(8'd5, 32'hAABBCCDD);
    issue("sh", 1'b1, F3_H, 32'h16, 32'h1234BEEF, 1'b0, 1'b1, 32'h8000F0FF, 4, -1, a0);
    wait_idle("sh");
    check32("sh_mem", mem[5], 32'hBEEFCCDD);

    // Busy: second request held during an SB; wrap of 0x400 to word 0
    preload(8'd6, 32'h0);
    preload(8'd0, 32'h0);
    issue("busy_sb", 1'b1, F3_B, 32'h18, 32'h0000005A, 1'b0, 1'b0, 32'h0, 4, -1, a0);
    issue("wrap_sw", 1'b1, F3_W, 32'h400, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, 2, a0 + 5, a1);
    wait_idle("busy");
    check32("busy_mem", mem[6], 32'h0000005A);
    check32("wrap_mem", mem[0], 32'hCAFEF00D);
    check32("wrap_wr_addr", {24'd0, wr_addr}, 32'd0);

    // Reset in CAPT of an SB: write dropped, no completion
    preload(8'd8, 32'h55667788);
    @(negedge iCLK);
    bus.iREQ = 1'b1; bus.iWE = 1'b1; bus.iFUNC3 = F3_B; bus.iADDR = 32'h20; bus.iWDATA = 32'h99;
    check32("rst_pre_ready", {31'd0, bus.oREADY}, 32'd1);
    @(posedge iCLK);
    #1 bus.iREQ = 1'b0;
    @(posedge iCLK);
    @(negedge iCLK);
    check32("rst_in_capt_ce", {31'd0, bus.oRAM_CE}, 32'd0);
    iRST = 1'b1;
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    check_reset_vals("midrst");
    iRST = 1'b0;
    repeat (4) @(negedge iCLK);
    check32("midrst_mem", mem[8], 32'h55667788);
    check32("midrst_ready", {31'd0, bus.oREADY}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
